median_window_fifo: RTL and testbench

- Upstream feeder of the median cell array.
- Holds the last W samples of the input stream in a circular buffer.
- For every accepted sample it presents the new sample (X) and the sample leaving the window (R_old) to the array in the same output beat.
- Flags whether R_old is a real evicted sample, so the array distinguishes fill-up from steady-state operation.

---
 rtl/median_window_fifo.sv | 152 +++++++++++++++
 tb/tb_median_window_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/median_window_fifo.sv
// Circular-buffer feeder for the median cell array: emits (X, R_old, old_valid)
// per accepted sample. Optional fill_level port under MEDIAN_WINDOW_FIFO_OCC_EN.
//
// Ports:
//   clk, reset (async, active-low)
//   W          requested window size, latched while EMPTY (clamped 1..WMAX)
//   flush      synchronous clear of window state
//   in_valid/in_data/in_ready    input handshake
//   out_valid/out_ready          output handshake
//   X          newest sample
//   R_old      evicted sample (0 when old_valid=0)
//   old_valid  R_old is a genuine evicted sample
//   fill_level occupancy 0..W_reg (only with MEDIAN_WINDOW_FIFO_OCC_EN)
module median_window_fifo #(
  parameter int DATA_LENGTH = 32,
  parameter int WMAX        = 16,
  parameter int LOG_WMAX    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LOG_WMAX:0]      W,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DATA_LENGTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_LENGTH-1:0] X,
  output logic [DATA_LENGTH-1:0] R_old,
  output logic                   old_valid
`ifdef MEDIAN_WINDOW_FIFO_OCC_EN
  ,
  output logic [LOG_WMAX:0]      fill_level
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILL,
    S_FULL
  } state_t;

  localparam logic [LOG_WMAX:0] LP_WMAX = (LOG_WMAX+1)'(WMAX);
  localparam logic [LOG_WMAX:0] LP_ONE  = (LOG_WMAX+1)'(1);

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_LENGTH-1:0] r_mem [WMAX];
  logic [LOG_WMAX-1:0]    r_wp;
  logic [LOG_WMAX:0]      r_cnt;
  logic [LOG_WMAX:0]      r_wreg;
  logic [LOG_WMAX:0]      w_wclamp;
  logic [LOG_WMAX:0]      w_cnt_inc;
  logic                   w_acc;
  logic                   w_wrap;

  logic                   r_out_valid;
  logic [DATA_LENGTH-1:0] r_x;
  logic [DATA_LENGTH-1:0] r_old;
  logic                   r_old_valid;

  assign in_ready  = ~flush & (~r_out_valid | out_ready);
  assign w_acc     = in_valid & in_ready;
  assign w_cnt_inc = r_cnt + LP_ONE;
  assign w_wrap    = ({1'b0, r_wp} == (r_wreg - LP_ONE));

  assign out_valid = r_out_valid;
  assign X         = r_x;
  assign R_old     = r_old;
  assign old_valid = r_old_valid;

`ifdef MEDIAN_WINDOW_FIFO_OCC_EN
  // cnt already updates on the same edge as the state register
  assign fill_level = r_cnt;
`endif

  always_comb begin
    w_wclamp = W;
    unique case (1'b1)
      (W == '0):     w_wclamp = LP_ONE;
      (W > LP_WMAX): w_wclamp = LP_WMAX;
      default:       w_wclamp = W;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else if (w_acc) begin
      unique case (r_state)
        S_EMPTY:
          w_state_nxt = (r_wreg == LP_ONE) ? S_FULL : S_FILL;
        S_FILL:
          if (w_cnt_inc == r_wreg) w_state_nxt = S_FULL;
        S_FULL:
          w_state_nxt = S_FULL;
        default:
          w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp   <= '0;
      r_cnt  <= '0;
      r_wreg <= LP_ONE;
    end else begin
      if (r_state == S_EMPTY) r_wreg <= w_wclamp;
      if (flush) begin
        r_wp  <= '0;
        r_cnt <= '0;
      end else if (w_acc) begin
        r_wp <= w_wrap ? '0 : r_wp + LOG_WMAX'(1);
        if (r_cnt != r_wreg) r_cnt <= w_cnt_inc;
      end
    end
  end

  // Storage is left uncleared; R_old is masked until the window is full.
  always_ff @(posedge clk) begin
    if (w_acc) r_mem[r_wp] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_x         <= '0;
      r_old       <= '0;
      r_old_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_old       <= '0;
      r_old_valid <= 1'b0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_x         <= in_data;
      r_old       <= (r_state == S_FULL) ? r_mem[r_wp] : '0;
      r_old_valid <= (r_state == S_FULL);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_median_window_fifo.sv
// Directed table-driven bench for median_window_fifo (DATA_LENGTH=8, WMAX=8).
// Optional fill_level checks when MEDIAN_WINDOW_FIFO_OCC_EN is defined.
module tb_median_window_fifo;

  localparam int DL = 8;
  localparam int WM = 8;
  localparam int LW = 3;

  logic          clk;
  logic          reset;
  logic [LW:0]   W;
  logic          flush;
  logic          in_valid;
  logic [DL-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DL-1:0] X;
  logic [DL-1:0] R_old;
  logic          old_valid;
`ifdef MEDIAN_WINDOW_FIFO_OCC_EN
  logic [LW:0]   fill_level;
`endif

  median_window_fifo #(
    .DATA_LENGTH(DL),
    .WMAX(WM),
    .LOG_WMAX(LW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .W(W),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .X(X),
    .R_old(R_old),
    .old_valid(old_valid)
`ifdef MEDIAN_WINDOW_FIFO_OCC_EN
    ,
    .fill_level(fill_level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LW:0]   w;
    logic          fl;
    logic          iv;
    logic [DL-1:0] d;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic [DL-1:0] e_x;
    logic          e_oldv;
    logic [DL-1:0] e_r;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  function automatic void add(input int w, input bit fl, input bit iv,
                              input int d, input bit ordy, input bit ir,
                              input bit ov, input int x, input bit oldv,
                              input int r);
    vec_t v;
    v.w = (LW+1)'(w);
    v.fl = fl;
    v.iv = iv;
    v.d = DL'(d);
    v.ordy = ordy;
    v.e_ir = ir;
    v.e_ov = ov;
    v.e_x = DL'(x);
    v.e_oldv = oldv;
    v.e_r = DL'(r);
    tv.push_back(v);
  endfunction

  // push with out_ready=1: beat (d, oldv, r) expected after the edge
  function automatic void push(input int w, input int d, input bit oldv,
                               input int r);
    add(w, 0, 1, d, 1, 1, 1, d, oldv, r);
  endfunction

  task automatic beat(input string tag, input int x, input bit oldv,
                      input int r);
    chk({tag, ".out_valid"}, 32'(out_valid), 1);
    chk({tag, ".X"}, 32'(X), 32'(x));
    chk({tag, ".old_valid"}, 32'(old_valid), 32'(oldv));
    chk({tag, ".R_old"}, 32'(R_old), 32'(r));
  endtask

  task automatic drive(input int w, input bit iv, input int d);
    W = (LW+1)'(w);
    flush = 1'b0;
    in_valid = iv;
    in_data = DL'(d);
    out_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    W = 4'd3;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;

    // scenario 1: W=3, five back-to-back samples
    add(3, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    push(3, 10, 0, 0);
    push(3, 20, 0, 0);
    push(3, 30, 0, 0);
    push(3, 40, 1, 10);
    push(3, 50, 1, 20);
    add(3, 0, 0, 0, 1, 1, 0, 50, 1, 20);
    // scenario 2: fresh window, 1..9
    add(3, 1, 0, 0, 1, 0, 0, 50, 0, 0);
    add(3, 0, 0, 0, 1, 1, 0, 50, 0, 0);
    for (int k = 1; k <= 9; k++)
      push(3, k, k >= 4, (k >= 4) ? k - 3 : 0);
    add(3, 0, 0, 0, 1, 1, 0, 9, 1, 6);
    // scenario 3: stall after first beat
    add(3, 1, 0, 0, 1, 0, 0, 9, 0, 0);
    add(3, 0, 0, 0, 1, 1, 0, 9, 0, 0);
    push(3, 10, 0, 0);
    for (int k = 0; k < 4; k++)
      add(3, 0, 1, 20, 0, 0, 1, 10, 0, 0);
    push(3, 20, 0, 0);
    add(3, 0, 0, 0, 1, 1, 0, 20, 0, 0);
    // scenario 4: flush from FULL beats a concurrent sample, then W=2
    add(3, 1, 0, 0, 1, 0, 0, 20, 0, 0);
    add(3, 0, 0, 0, 1, 1, 0, 20, 0, 0);
    push(3, 10, 0, 0);
    push(3, 20, 0, 0);
    push(3, 30, 0, 0);
    push(3, 40, 1, 10);
    add(2, 1, 1, 99, 1, 0, 0, 40, 0, 0);
    add(2, 0, 0, 0, 1, 1, 0, 40, 0, 0);
    push(2, 5, 0, 0);
    push(2, 6, 0, 0);
    push(2, 7, 1, 5);
    add(2, 0, 0, 0, 1, 1, 0, 7, 1, 5);
    // scenario 5a: W=0 clamps to 1; later W change ignored while FULL
    add(0, 1, 0, 0, 1, 0, 0, 7, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 7, 0, 0);
    push(0, 3, 0, 0);
    push(0, 4, 1, 3);
    push(5, 8, 1, 4);
    add(5, 0, 0, 0, 1, 1, 0, 8, 1, 4);
    // scenario 5b: W=12 clamps to 8
    add(12, 1, 0, 0, 1, 0, 0, 8, 0, 0);
    add(12, 0, 0, 0, 1, 1, 0, 8, 0, 0);
    for (int k = 1; k <= 8; k++) push(12, k, 0, 0);
    push(12, 9, 1, 1);
    push(12, 10, 1, 2);
    add(12, 0, 0, 0, 1, 1, 0, 10, 1, 2);
    // prepare for scenario 6
    add(3, 1, 0, 0, 1, 0, 0, 10, 0, 0);
    add(3, 0, 0, 0, 1, 1, 0, 10, 0, 0);
    push(3, 11, 0, 0);
    push(3, 12, 0, 0);

    // reset state
    #12;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.X", 32'(X), 0);
    chk("rst.R_old", 32'(R_old), 0);
    chk("rst.old_valid", 32'(old_valid), 0);
    chk("rst.in_ready", 32'(in_ready), 1);
`ifdef MEDIAN_WINDOW_FIFO_OCC_EN
    chk("rst.fill_level", 32'(fill_level), 0);
`endif
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      W = tv[i].w;
      flush = tv[i].fl;
      in_valid = tv[i].iv;
      in_data = tv[i].d;
      out_ready = tv[i].ordy;
      #1;
      chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(tv[i].e_ir));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid),
          32'(tv[i].e_ov));
      chk($sformatf("v%0d.X", i), 32'(X), 32'(tv[i].e_x));
      chk($sformatf("v%0d.old_valid", i), 32'(old_valid),
          32'(tv[i].e_oldv));
      chk($sformatf("v%0d.R_old", i), 32'(R_old), 32'(tv[i].e_r));
    end

    // scenario 6: asynchronous reset mid-FILL, between edges
    drive(3, 0, 0);
`ifdef MEDIAN_WINDOW_FIFO_OCC_EN
    chk("s6.fill_pre", 32'(fill_level), 2);
`endif
    #2 reset = 1'b0;
    #1;
    chk("s6.out_valid", 32'(out_valid), 0);
    chk("s6.X", 32'(X), 0);
    chk("s6.R_old", 32'(R_old), 0);
    chk("s6.old_valid", 32'(old_valid), 0);
`ifdef MEDIAN_WINDOW_FIFO_OCC_EN
    chk("s6.fill_level", 32'(fill_level), 0);
`endif
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 5; k++) begin
      drive(3, 1, 100 + k);
      @(posedge clk);
      #1;
      beat($sformatf("s6.b%0d", k), 100 + k, k >= 4,
           (k >= 4) ? 100 + k - 3 : 0);
`ifdef MEDIAN_WINDOW_FIFO_OCC_EN
      chk($sformatf("s6.fill%0d", k), 32'(fill_level),
          (k < 3) ? k : 3);
`endif
    end
    drive(3, 0, 0);
    @(posedge clk);
    #1;
    chk("s6.drain", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
